// File: rtl/hash_table_ctrl_pkg.sv
// Shared definitions for the hash table controller: request opcodes and
// controller state encoding.
package hash_pkg;

   localparam logic OP_LOOKUP = 1'b0;
   localparam logic OP_INSERT = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      PROBE,
      RESP
   } state_t;

endpackage

// File: rtl/hash_function.sv
// Home-slot hash: the low-order key bits select the slot (TABLE_SIZE is a
// power of two, so this is key mod TABLE_SIZE).
module hash_function #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned TABLE_SIZE = 16
) (
   input  logic [WIDTH-1:0]              key,
   output logic [$clog2(TABLE_SIZE)-1:0] hash_index
);

   localparam int unsigned IDX_W = $clog2(TABLE_SIZE);

   logic unused_hi;

   assign hash_index = key[IDX_W-1:0];
   assign unused_hi  = ^key[WIDTH-1:IDX_W];

endmodule

// File: rtl/hash_table_ctrl.sv
// Hash-table lookup/insert engine with linear probing over a register-array
// table. Optional statistics outputs (occupancy, collision_count) are enabled
// by defining HASH_TABLE_STATS_EN.
module hash_table_ctrl
   import hash_pkg::*;
#(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned VAL_WIDTH  = 32,
   parameter int unsigned TABLE_SIZE = 16,
   parameter int unsigned MAX_PROBE  = TABLE_SIZE
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic                          req_op,
   input  logic [WIDTH-1:0]              req_key,
   input  logic [VAL_WIDTH-1:0]          req_value,
   output logic                          resp_valid,
   input  logic                          resp_ready,
   output logic                          resp_hit,
   output logic [VAL_WIDTH-1:0]          resp_value,
   output logic [$clog2(TABLE_SIZE)-1:0] resp_index,
`ifdef HASH_TABLE_STATS_EN
   output logic [$clog2(TABLE_SIZE):0]   occupancy,
   output logic [15:0]                   collision_count,
`endif
   output logic                          resp_full
);

   localparam int unsigned IDX_W = $clog2(TABLE_SIZE);
   localparam int unsigned CNT_W = $clog2(TABLE_SIZE) + 1;

   typedef struct packed {
      logic                 valid;
      logic [WIDTH-1:0]     key;
      logic [VAL_WIDTH-1:0] value;
   } entry_t;

   state_t                state;
   logic                  op_q;
   logic [WIDTH-1:0]      key_q;
   logic [VAL_WIDTH-1:0]  val_q;
   logic [IDX_W-1:0]      idx;
   logic [CNT_W-1:0]      cnt;
   logic [IDX_W-1:0]      home_idx;

   logic [TABLE_SIZE-1:0] slot_valid;
   logic [WIDTH-1:0]      slot_key [TABLE_SIZE];
   logic [VAL_WIDTH-1:0]  slot_val [TABLE_SIZE];

   entry_t                cur;
   logic                  key_match;
   logic                  last_probe;
   logic                  step;
   logic                  wr_key;
   logic                  wr_val;

   hash_function #(
      .WIDTH      (WIDTH),
      .TABLE_SIZE (TABLE_SIZE)
   ) u_hash (
      .key        (req_key),
      .hash_index (home_idx)
   );

   assign req_ready = (state == IDLE) && !rst;

   // Decode the slot under examination and derive the write/advance strobes
   always_comb begin
      cur        = '{valid: slot_valid[idx], key: slot_key[idx], value: slot_val[idx]};
      key_match  = cur.valid && (cur.key == key_q);
      last_probe = (cnt == CNT_W'(MAX_PROBE - 1));
      step       = (state == PROBE) && cur.valid && !key_match && !last_probe;
      wr_key     = (state == PROBE) && (op_q == OP_INSERT) && !cur.valid;
      wr_val     = (state == PROBE) && (op_q == OP_INSERT) && (!cur.valid || key_match);
   end

   // Key/value storage: not reset, only meaningful where slot_valid is set
   always_ff @(posedge clk) begin
      if (wr_key) slot_key[idx] <= key_q;
      if (wr_val) slot_val[idx] <= val_q;
   end

   // Controller FSM with registered response outputs and slot valid bits
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         op_q       <= OP_LOOKUP;
         key_q      <= '0;
         val_q      <= '0;
         idx        <= '0;
         cnt        <= '0;
         slot_valid <= '0;
         resp_valid <= 1'b0;
         resp_hit   <= 1'b0;
         resp_full  <= 1'b0;
         resp_value <= '0;
         resp_index <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  op_q  <= req_op;
                  key_q <= req_key;
                  val_q <= req_value;
                  idx   <= home_idx;
                  cnt   <= '0;
                  state <= PROBE;
               end
            end
            PROBE: begin
               if (key_match) begin
                  resp_hit   <= 1'b1;
                  resp_full  <= 1'b0;
                  resp_value <= (op_q == OP_LOOKUP) ? cur.value : '0;
                  resp_index <= idx;
                  resp_valid <= 1'b1;
                  state      <= RESP;
               end else if (!cur.valid) begin
                  if (op_q == OP_INSERT) slot_valid[idx] <= 1'b1;
                  resp_hit   <= 1'b0;
                  resp_full  <= 1'b0;
                  resp_value <= '0;
                  resp_index <= idx;
                  resp_valid <= 1'b1;
                  state      <= RESP;
               end else if (last_probe) begin
                  resp_hit   <= 1'b0;
                  resp_full  <= 1'b1;
                  resp_value <= '0;
                  resp_index <= idx;
                  resp_valid <= 1'b1;
                  state      <= RESP;
               end else begin
                  idx <= idx + 1'b1;
                  cnt <= cnt + 1'b1;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef HASH_TABLE_STATS_EN
   // Occupancy counts new-slot inserts; collisions count probe advances
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occupancy       <= '0;
         collision_count <= '0;
      end else begin
         if (wr_key) occupancy <= occupancy + 1'b1;
         if (step && (collision_count != 16'hFFFF))
            collision_count <= collision_count + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_hash_table_ctrl.sv
// Directed self-checking bench for hash_table_ctrl (TABLE_SIZE=16,
// MAX_PROBE=16, home slot = key[3:0]). Checks statistics outputs when
// HASH_TABLE_STATS_EN is defined.
module tb_hash_table_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_op = 1'b0;
   logic [31:0] req_key = '0;
   logic [31:0] req_value = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic        resp_hit;
   logic [31:0] resp_value;
   logic [3:0]  resp_index;
   logic        resp_full;
`ifdef HASH_TABLE_STATS_EN
   logic [4:0]  occupancy;
   logic [15:0] collision_count;
`endif

   int tests = 0;
   int fails = 0;

   hash_table_ctrl #(
      .WIDTH      (32),
      .VAL_WIDTH  (32),
      .TABLE_SIZE (16),
      .MAX_PROBE  (16)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_op          (req_op),
      .req_key         (req_key),
      .req_value       (req_value),
      .resp_valid      (resp_valid),
      .resp_ready      (resp_ready),
      .resp_hit        (resp_hit),
      .resp_value      (resp_value),
      .resp_index      (resp_index),
`ifdef HASH_TABLE_STATS_EN
      .occupancy       (occupancy),
      .collision_count (collision_count),
`endif
      .resp_full       (resp_full)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_req(input logic op, input logic [31:0] key, input logic [31:0] val,
                         output int lat, output logic hit, output logic [31:0] value,
                         output logic [3:0] index, output logic full);
      int guard;
      @(negedge clk);
      req_op = op; req_key = key; req_value = val; req_valid = 1'b1;
      guard = 0;
      while (!req_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0;
      while (!resp_valid && lat < 64) begin
         @(posedge clk);
         #1 lat++;
      end
      if (!resp_valid) check("resp_timeout", 64'(resp_valid), 64'd1);
      hit = resp_hit; value = resp_value; index = resp_index; full = resp_full;
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
   endtask

   task automatic req_check(input string tag, input logic op, input logic [31:0] key,
                            input logic [31:0] val, input logic e_hit, input logic [31:0] e_val,
                            input logic [3:0] e_idx, input logic e_full, input int e_lat);
      int lat; logic hit; logic [31:0] value; logic [3:0] index; logic full;
      do_req(op, key, val, lat, hit, value, index, full);
      check({tag, ".hit"},   64'(hit),   64'(e_hit));
      check({tag, ".value"}, 64'(value), 64'(e_val));
      check({tag, ".index"}, 64'(index), 64'(e_idx));
      check({tag, ".full"},  64'(full),  64'(e_full));
      check({tag, ".lat"},   64'(lat),   64'(e_lat));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
   endtask

   initial begin : stimulus
      int lat; logic hit; logic [31:0] value; logic [3:0] index; logic full;
      int guard;

      // Reset state
      #2;
      check("rst.req_ready",  64'(req_ready),  64'd0);
      check("rst.resp_valid", 64'(resp_valid), 64'd0);
      check("rst.resp_hit",   64'(resp_hit),   64'd0);
      check("rst.resp_full",  64'(resp_full),  64'd0);
      check("rst.resp_value", 64'(resp_value), 64'd0);
      check("rst.resp_index", 64'(resp_index), 64'd0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      #1 check("post_rst.req_ready", 64'(req_ready), 64'd1);

      // Empty-table lookup and basic insert/overwrite
      req_check("lk05",    1'b0, 32'h05, 32'h0,  1'b0, 32'h0,  4'd5, 1'b0, 1);
      req_check("ins13",   1'b1, 32'h13, 32'hAA, 1'b0, 32'h0,  4'd3, 1'b0, 1);
      req_check("lk13a",   1'b0, 32'h13, 32'h0,  1'b1, 32'hAA, 4'd3, 1'b0, 1);
      req_check("reins13", 1'b1, 32'h13, 32'hBB, 1'b1, 32'h0,  4'd3, 1'b0, 1);
      req_check("lk13b",   1'b0, 32'h13, 32'h0,  1'b1, 32'hBB, 4'd3, 1'b0, 1);

      // Collisions and wrap
      do_reset();
      req_check("ins03",  1'b1, 32'h03, 32'h30, 1'b0, 32'h0,  4'd3,  1'b0, 1);
      req_check("cins13", 1'b1, 32'h13, 32'h31, 1'b0, 32'h0,  4'd4,  1'b0, 2);
      req_check("clk13",  1'b0, 32'h13, 32'h0,  1'b1, 32'h31, 4'd4,  1'b0, 2);
      req_check("ins0F",  1'b1, 32'h0F, 32'hF0, 1'b0, 32'h0,  4'd15, 1'b0, 1);
      req_check("ins1F",  1'b1, 32'h1F, 32'hF1, 1'b0, 32'h0,  4'd0,  1'b0, 2);
      req_check("lk1F",   1'b0, 32'h1F, 32'h0,  1'b1, 32'hF1, 4'd0,  1'b0, 2);
`ifdef HASH_TABLE_STATS_EN
      check("coll.occupancy", 64'(occupancy),       64'd4);
      check("coll.collision", 64'(collision_count), 64'd4);
`endif

      // Reset while probing (0x23 walks 3 -> 4 -> 5)
      @(negedge clk);
      req_op = 1'b1; req_key = 32'h23; req_value = 32'h77; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      #2;
      check("midrst.resp_valid", 64'(resp_valid), 64'd0);
      check("midrst.req_ready",  64'(req_ready),  64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1 check("midrst.req_ready_rel", 64'(req_ready), 64'd1);
      check("midrst.resp_valid_rel", 64'(resp_valid), 64'd0);
`ifdef HASH_TABLE_STATS_EN
      check("midrst.occupancy", 64'(occupancy),       64'd0);
      check("midrst.collision", 64'(collision_count), 64'd0);
`endif
      req_check("midrst.lk13", 1'b0, 32'h13, 32'h0, 1'b0, 32'h0, 4'd3, 1'b0, 1);

      // Full table
      do_reset();
      for (int i = 0; i < 16; i++) begin
         do_req(1'b1, 32'(i), 32'h100 + 32'(i), lat, hit, value, index, full);
         check("fill.index", 64'(index), 64'(i));
         check("fill.hit",   64'(hit),   64'd0);
      end
      req_check("full.ins10", 1'b1, 32'h10, 32'h999, 1'b0, 32'h0,   4'd15, 1'b1, 16);
      req_check("full.lk10",  1'b0, 32'h10, 32'h0,   1'b0, 32'h0,   4'd15, 1'b1, 16);
      req_check("full.lk00",  1'b0, 32'h00, 32'h0,   1'b1, 32'h100, 4'd0,  1'b0, 1);
      req_check("full.ins0A", 1'b1, 32'h0A, 32'h55,  1'b1, 32'h0,   4'd10, 1'b0, 1);
`ifdef HASH_TABLE_STATS_EN
      check("full.occupancy", 64'(occupancy),       64'd16);
      check("full.collision", 64'(collision_count), 64'd30);
`endif

      // Backpressure: response held, second request ignored
      @(negedge clk);
      req_op = 1'b0; req_key = 32'h0A; req_value = 32'h0; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      guard = 0;
      while (!resp_valid && guard < 64) begin
         @(posedge clk);
         #1 guard++;
      end
      check("bp.resp_valid0", 64'(resp_valid), 64'd1);
      for (int c = 0; c < 5; c++) begin
         if (c == 1) begin
            req_op = 1'b1; req_key = 32'h99; req_value = 32'h77; req_valid = 1'b1;
         end
         @(posedge clk);
         #1;
         check("bp.resp_valid", 64'(resp_valid), 64'd1);
         check("bp.resp_hit",   64'(resp_hit),   64'd1);
         check("bp.resp_value", 64'(resp_value), 64'h55);
         check("bp.resp_index", 64'(resp_index), 64'd10);
         check("bp.resp_full",  64'(resp_full),  64'd0);
         check("bp.req_ready",  64'(req_ready),  64'd0);
      end
      req_valid = 1'b0;
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
      check("bp.done.resp_valid", 64'(resp_valid), 64'd0);
      check("bp.done.req_ready",  64'(req_ready),  64'd1);
      req_check("bp.lk99", 1'b0, 32'h99, 32'h0, 1'b0, 32'h0, 4'd8, 1'b1, 16);
`ifdef HASH_TABLE_STATS_EN
      check("bp.occupancy", 64'(occupancy),       64'd16);
      check("bp.collision", 64'(collision_count), 64'd45);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
